store_buffer: RTL and testbench

Posted-write buffer between the EX/MEM pipeline register and the data memory. Stores from the MEM stage are queued in a small FIFO, and the FIFO drains one entry per cycle into the memory write port whenever no load is using the shared memory address port. Loads are forwarded from the youngest matching buffered store, so a load never returns a value older than a queued store. The pipeline therefore never stalls on a store unless the buffer is full.

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 80 ++++++++
 tb/tb_store_buffer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Bus between the MEM stage and the store buffer: store push, load forwarding,
// and the data-memory write port driven by the buffer drain.
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                     st_valid;
  logic [ADDR_W-1:0]        st_addr;
  logic [DATA_W-1:0]        st_data;
  logic                     st_ready;
  logic                     ld_valid;
  logic [ADDR_W-1:0]        ld_addr;
  logic                     ld_hit;
  logic [DATA_W-1:0]        ld_data;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_hit, ld_data, mem_write, mem_addr, mem_wdata, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_hit, ld_data, mem_write, mem_addr, mem_wdata, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and data memory; drains when no load owns
// the address port and forwards the youngest matching queued store to loads.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              ready;
  logic              is_empty;
  logic              push;
  logic              pop;
  logic              hit;
  logic [DATA_W-1:0] fwd;
  logic [PTR_W-1:0]  idx;

  // Ready comes from registered count only, so a same-cycle pop never frees a slot.
  assign ready    = (count < CNT_W'(DEPTH));
  assign is_empty = (count == '0);
  assign push     = sb.st_valid & ready;
  assign pop      = ~is_empty & ~sb.ld_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= sb.st_addr;
      data_q[tail] <= sb.st_data;
    end
  end

  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = head;
    // Walk oldest to youngest so the last match seen is the youngest one.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[idx] == sb.ld_addr)) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end

  assign sb.st_ready  = ready;
  assign sb.empty     = is_empty;
  assign sb.count     = count;
  assign sb.mem_write = pop;
  assign sb.mem_addr  = addr_q[head];
  assign sb.mem_wdata = data_q[head];
  assign sb.ld_hit    = hit;
  assign sb.ld_data   = fwd;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a
// queue-based model of buffered stores and the memory write sequence.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus.slave)
  );

  ent_t mq[$];
  ent_t exp_log[$];
  ent_t dut_log[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic logic m_hit(input logic [ADDR_W-1:0] a);
    foreach (mq[i]) if (mq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] m_data(input logic [ADDR_W-1:0] a);
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].a == a) return mq[i].d;
    return '0;
  endfunction

  // Advance one clock: record DUT memory writes and update the model.
  task automatic tick();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    #1;
    if (!reset && bus.mem_write === 1'b1) begin
      e.a = bus.mem_addr;
      e.d = bus.mem_wdata;
      dut_log.push_back(e);
    end
    do_pop  = (mq.size() != 0) && !bus.ld_valid;
    do_push = bus.st_valid && (mq.size() < DEPTH);
    e.a = bus.st_addr;
    e.d = bus.st_data;
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      if (do_pop) exp_log.push_back(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.count !== '0) begin n_fail++; $display("FAIL rst_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.st_ready); end
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_memwr got %b want 0", bus.mem_write); end
    n_cmp++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== '0) begin n_fail++; $display("FAIL rst_fwd got %b/%h want 0/0", bus.ld_hit, bus.ld_data); end
  endtask

  task automatic test_basic_drain();
    dut_log.delete(); exp_log.delete();
    bus.ld_valid = 1'b0;
    bus.st_valid = 1'b1; bus.st_addr = 32'h4; bus.st_data = 32'hAAAA;
    tick();
    bus.st_addr = 32'h8; bus.st_data = 32'hBBBB;
    #1;
    n_cmp++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h4 || bus.mem_wdata !== 32'hAAAA) begin
      n_fail++; $display("FAIL drain_first got %b %h %h want 1 4 aaaa", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
    tick();
    bus.st_valid = 1'b0;
    #1;
    n_cmp++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h8 || bus.mem_wdata !== 32'hBBBB) begin
      n_fail++; $display("FAIL drain_second got %b %h %h want 1 8 bbbb", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
    tick();
    n_cmp++; if (bus.empty !== 1'b1 || bus.mem_write !== 1'b0) begin
      n_fail++; $display("FAIL drain_done got empty=%b memwr=%b want 1 0", bus.empty, bus.mem_write); end
    n_cmp++; if (dut_log.size() != 2 || dut_log[0] !== {32'h4, 32'hAAAA} || dut_log[1] !== {32'h8, 32'hBBBB}) begin
      n_fail++; $display("FAIL drain_order got %0d writes want 2 in order 4,8", dut_log.size()); end
  endtask

  task automatic test_fill();
    dut_log.delete(); exp_log.delete();
    bus.ld_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.st_valid = 1'b1; bus.st_addr = 32'h100 + 32'(4 * i); bus.st_data = $urandom;
      tick();
    end
    bus.st_valid = 1'b0;
    #1;
    n_cmp++; if (bus.count !== CNT_W'(DEPTH) || bus.st_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full got count=%0d ready=%b want 4 0", bus.count, bus.st_ready); end
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL fill_nodrain got %b want 0", bus.mem_write); end
    bus.st_valid = 1'b1; bus.st_addr = 32'h200; bus.st_data = 32'hDEAD;
    tick();
    bus.st_valid = 1'b0;
    #1;
    n_cmp++; if (bus.count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL fill_reject got count=%0d want 4", bus.count); end
    bus.ld_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_cmp++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h100 + 32'(4 * i)) begin
        n_fail++; $display("FAIL fill_drain%0d got %b %h want 1 %h", i, bus.mem_write, bus.mem_addr, 32'h100 + 32'(4 * i)); end
      tick();
    end
    n_cmp++; if (bus.empty !== 1'b1 || bus.count !== '0) begin
      n_fail++; $display("FAIL fill_empty got empty=%b count=%0d want 1 0", bus.empty, bus.count); end
  endtask

  task automatic test_forward();
    logic [DATA_W-1:0] want;
    bus.ld_valid = 1'b1;
    bus.st_valid = 1'b1; bus.st_addr = 32'h10; bus.st_data = 32'd1; tick();
    bus.st_addr = 32'h10; bus.st_data = 32'd2; tick();
    bus.st_addr = 32'h14; bus.st_data = 32'd3; tick();
    bus.st_valid = 1'b0;
    bus.ld_addr = 32'h10; #1;
    want = m_data(32'h10);
    n_cmp++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd2 || want !== 32'd2) begin
      n_fail++; $display("FAIL fwd_young got %b/%0d want 1/2", bus.ld_hit, bus.ld_data); end
    bus.ld_addr = 32'h14; #1;
    n_cmp++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd3) begin
      n_fail++; $display("FAIL fwd_14 got %b/%0d want 1/3", bus.ld_hit, bus.ld_data); end
    bus.ld_addr = 32'h18; #1;
    n_cmp++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== '0) begin
      n_fail++; $display("FAIL fwd_miss got %b/%0d want 0/0", bus.ld_hit, bus.ld_data); end
    // Head stays forwardable during its drain cycle.
    bus.ld_valid = 1'b0; bus.ld_addr = 32'h14; #1;
    n_cmp++; if (bus.mem_write !== 1'b1 || bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd3) begin
      n_fail++; $display("FAIL fwd_drain got %b %b/%0d want 1 1/3", bus.mem_write, bus.ld_hit, bus.ld_data); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fwd_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_wrap();
    int k;
    dut_log.delete(); exp_log.delete();
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.st_valid = 1'b1; bus.st_addr = 32'h300 + 32'(4 * i); bus.st_data = $urandom; tick();
    end
    bus.ld_valid = 1'b0;
    for (int i = 2; i < 8; i++) begin
      bus.st_addr = 32'h300 + 32'(4 * i); bus.st_data = $urandom;
      tick();
      n_cmp++; if (bus.count !== CNT_W'(2)) begin n_fail++; $display("FAIL wrap_count%0d got %0d want 2", i, bus.count); end
    end
    bus.st_valid = 1'b0;
    tick(); tick();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < dut_log.size() && dut_log[i].a === 32'h300 + 32'(4 * i) && dut_log[i] === exp_log[i]) k++;
    end
    n_cmp++; if (dut_log.size() != 8 || k != 8) begin
      n_fail++; $display("FAIL wrap_order got %0d writes %0d in order want 8 8", dut_log.size(), k); end
  endtask

  task automatic test_same_cycle();
    logic [DATA_W-1:0] d;
    d = $urandom;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h20;
    bus.st_valid = 1'b1; bus.st_addr = 32'h20; bus.st_data = d;
    #1;
    n_cmp++; if (bus.ld_hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle got %b want 0", bus.ld_hit); end
    tick();
    bus.st_valid = 1'b0;
    #1;
    n_cmp++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== d) begin
      n_fail++; $display("FAIL next_cycle got %b/%h want 1/%h", bus.ld_hit, bus.ld_data, d); end
    bus.ld_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    dut_log.delete(); exp_log.delete();
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.st_valid = 1'b1; bus.st_addr = 32'h400 + 32'(4 * i); bus.st_data = $urandom; tick();
    end
    bus.st_valid = 1'b0;
    #1;
    n_cmp++; if (bus.count !== CNT_W'(3)) begin n_fail++; $display("FAIL rmid_pre got %0d want 3", bus.count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.mem_write !== 1'b0) begin
      n_fail++; $display("FAIL rmid_post got count=%0d empty=%b memwr=%b want 0 1 0", bus.count, bus.empty, bus.mem_write); end
    bus.ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (dut_log.size() != 0) begin n_fail++; $display("FAIL rmid_leak got %0d writes want 0", dut_log.size()); end
  endtask

  task automatic test_random();
    int k;
    dut_log.delete(); exp_log.delete();
    for (int c = 0; c < 400; c++) begin
      bus.st_valid = ($urandom_range(0, 99) < 60);
      bus.st_addr  = 32'(4 * $urandom_range(0, 7));
      bus.st_data  = $urandom;
      bus.ld_valid = ($urandom_range(0, 99) < 45);
      bus.ld_addr  = 32'(4 * $urandom_range(0, 7));
      reset        = ($urandom_range(0, 99) == 0);
      #1;
      n_cmp++; if (bus.count !== CNT_W'(mq.size()) || bus.empty !== (mq.size() == 0) || bus.st_ready !== (mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rnd_state c=%0d got %0d/%b/%b want %0d", c, bus.count, bus.empty, bus.st_ready, mq.size()); end
      n_cmp++; if (bus.mem_write !== ((mq.size() != 0) && !bus.ld_valid)) begin
        n_fail++; $display("FAIL rnd_memwr c=%0d got %b", c, bus.mem_write); end
      if (mq.size() != 0) begin
        n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== mq[0]) begin
          n_fail++; $display("FAIL rnd_head c=%0d got %h/%h want %h/%h", c, bus.mem_addr, bus.mem_wdata, mq[0].a, mq[0].d); end
      end
      n_cmp++; if (bus.ld_hit !== m_hit(bus.ld_addr) || bus.ld_data !== m_data(bus.ld_addr)) begin
        n_fail++; $display("FAIL rnd_fwd c=%0d got %b/%h want %b/%h", c, bus.ld_hit, bus.ld_data, m_hit(bus.ld_addr), m_data(bus.ld_addr)); end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) tick();
    k = 0;
    foreach (dut_log[i]) if (i < exp_log.size() && dut_log[i] === exp_log[i]) k++;
    n_cmp++; if (dut_log.size() != exp_log.size() || k != exp_log.size()) begin
      n_fail++; $display("FAIL rnd_log got %0d writes %0d matching want %0d", dut_log.size(), k, exp_log.size()); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_drain();
    test_fill();
    test_forward();
    test_wrap();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
